// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that moves words from NREQ requesters into one synchronous FIFO, in bursts of up to MAX_BURST.
// Latency: one IDLE arbitration cycle per grant, then writes land the same cycle as ack; fifo_full stalls the owner in place.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    input  logic                   fifo_full,
    output logic                   fifo_wr,
    output logic [DATA_W-1:0]      fifo_data,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [15:0]            word_cnt
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [15:0] wcnt_q;

    logic              in_burst;
    logic              wr_int;
    logic [1:0]        rr_idx;
    logic [1:0]        rr_pick;
    logic              rr_found;
    logic [DATA_W-1:0] own_data;

    // Reset gates every output combinationally, so nothing leaks while rst is low.
    assign in_burst = rst && (state_q == BURST);
    assign wr_int   = in_burst && req[owner_q] && !fifo_full;

    // Search starts just after the previous owner and wraps modulo NREQ.
    always_comb begin
        rr_idx   = last_q;
        rr_pick  = last_q;
        rr_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_idx = last_q + 2'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 2'(i)) begin
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    owner_d = rr_pick;
                    bcnt_d  = 4'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (wr_int) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == 4'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'(NREQ - 1);
            bcnt_q  <= 4'd0;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            if (wr_int && (wcnt_q != 16'hFFFF)) begin
                wcnt_q <= wcnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        ack          = '0;
        ack[owner_q] = wr_int;
    end

    assign fifo_wr   = wr_int;
    assign fifo_data = in_burst ? own_data : '0;
    assign grant_id  = rst ? owner_q : 2'd0;
    assign busy      = in_burst;
    assign word_cnt  = rst ? wcnt_q : 16'd0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus a round-robin sequence.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] word_cnt;

    int total  = 0;
    int passed = 0;
    int row    = 0;

    fifo_wr_arbiter #(.DATA_W(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic [31:0] data;
        logic        wr;
        logic [3:0]  ack;
        logic [1:0]  gid;
        logic        busy;
        logic [7:0]  fdata;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic f, logic [31:0] d,
                                logic w, logic [3:0] a, logic [1:0] g, logic b,
                                logic [7:0] fd, logic [15:0] c);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.data = d;
        v.wr = w; v.ack = a; v.gid = g; v.busy = b; v.fdata = fd; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        logic [7:0] rr_byte [4];
        rr_byte[0] = 8'h11; rr_byte[1] = 8'h22; rr_byte[2] = 8'h33; rr_byte[3] = 8'h44;

        rst = 1'b0; req = 4'b0; req_data = 32'h0; fifo_full = 1'b0;

        // reset held, then first grant to requester 0
        vecs.push_back(mk(0, 4'b1111, 0, 32'h44332211, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 32'h44332211, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 32'h44332211, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 32'h44332211, 1, 4'b0001, 0, 1, 8'h11, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h44332211, 0, 4'b0000, 0, 1, 8'h11, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0));
        // single requester, 6 words: 4-word burst, one arbitration cycle, 2 more
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001000, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001000, 1, 4'b0010, 1, 1, 8'h10, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001100, 1, 4'b0010, 1, 1, 8'h11, 1));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001200, 1, 4'b0010, 1, 1, 8'h12, 2));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001300, 1, 4'b0010, 1, 1, 8'h13, 3));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001400, 0, 4'b0000, 1, 0, 8'h00, 4));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001400, 1, 4'b0010, 1, 1, 8'h14, 4));
        vecs.push_back(mk(1, 4'b0010, 0, 32'h00001500, 1, 4'b0010, 1, 1, 8'h15, 5));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 1, 1, 8'h00, 6));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 1, 0, 8'h00, 6));
        // full stall for 3 cycles after the 2nd word of owner 2
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00A00000, 0, 4'b0000, 1, 0, 8'h00, 6));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00A00000, 1, 4'b0100, 2, 1, 8'hA0, 6));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00A10000, 1, 4'b0100, 2, 1, 8'hA1, 7));
        vecs.push_back(mk(1, 4'b0100, 1, 32'h00A20000, 0, 4'b0000, 2, 1, 8'hA2, 8));
        vecs.push_back(mk(1, 4'b0100, 1, 32'h00A20000, 0, 4'b0000, 2, 1, 8'hA2, 8));
        vecs.push_back(mk(1, 4'b0100, 1, 32'h00A20000, 0, 4'b0000, 2, 1, 8'hA2, 8));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00A20000, 1, 4'b0100, 2, 1, 8'hA2, 8));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00A30000, 1, 4'b0100, 2, 1, 8'hA3, 9));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 2, 0, 8'h00, 10));
        // owner 1 drops after 2 words while requester 2 waits
        vecs.push_back(mk(1, 4'b0110, 0, 32'h00C0B000, 0, 4'b0000, 2, 0, 8'h00, 10));
        vecs.push_back(mk(1, 4'b0110, 0, 32'h00C0B000, 1, 4'b0010, 1, 1, 8'hB0, 10));
        vecs.push_back(mk(1, 4'b0110, 0, 32'h00C0B100, 1, 4'b0010, 1, 1, 8'hB1, 11));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00C0B100, 0, 4'b0000, 1, 1, 8'hB1, 12));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00C0B100, 0, 4'b0000, 1, 0, 8'h00, 12));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00C0B100, 1, 4'b0100, 2, 1, 8'hC0, 12));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 2, 1, 8'h00, 13));
        // reset during the 3rd word of owner 2, then lowest requester (2) wins over 3
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00D00000, 0, 4'b0000, 2, 0, 8'h00, 13));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00D00000, 1, 4'b0100, 2, 1, 8'hD0, 13));
        vecs.push_back(mk(1, 4'b0100, 0, 32'h00D10000, 1, 4'b0100, 2, 1, 8'hD1, 14));
        vecs.push_back(mk(0, 4'b1100, 0, 32'hE0D20000, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 32'hE0D20000, 0, 4'b0000, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 32'hE0D20000, 1, 4'b0100, 2, 1, 8'hD2, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 32'h00000000, 0, 4'b0000, 2, 1, 8'h00, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            row       = i;
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            fifo_full = vecs[i].full;
            req_data  = vecs[i].data;
            #1;
            chk("fifo_wr",   32'(fifo_wr),   32'(vecs[i].wr));
            chk("ack",       32'(ack),       32'(vecs[i].ack));
            chk("grant_id",  32'(grant_id),  32'(vecs[i].gid));
            chk("busy",      32'(busy),      32'(vecs[i].busy));
            chk("fifo_data", 32'(fifo_data), 32'(vecs[i].fdata));
            chk("word_cnt",  32'(word_cnt),  32'(vecs[i].cnt));
        end

        // round robin with all four requesting: 0,1,2,3,0, four words each
        row = 1000;
        @(negedge clk);
        rst = 1'b0; req = 4'b0000; req_data = 32'h44332211; fifo_full = 1'b0;
        #1;
        chk("rr_reset_cnt", 32'(word_cnt), 32'd0);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            row = 1000 + b * 10;
            rst = 1'b1; req = 4'b1111;
            #1;
            chk("rr_arb_busy", 32'(busy),    32'd0);
            chk("rr_arb_wr",   32'(fifo_wr), 32'd0);
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                row = 1000 + b * 10 + w + 1;
                #1;
                chk("rr_wr",    32'(fifo_wr),   32'd1);
                chk("rr_busy",  32'(busy),      32'd1);
                chk("rr_grant", 32'(grant_id),  32'(b % 4));
                chk("rr_ack",   32'(ack),       32'd1 << (b % 4));
                chk("rr_data",  32'(fifo_data), 32'(rr_byte[b % 4]));
            end
        end
        @(negedge clk);
        row = 1100;
        req = 4'b0000;
        #1;
        chk("rr_word_cnt", 32'(word_cnt), 32'd20);
        chk("rr_end_busy", 32'(busy),     32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
